// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, register/word types, zero-register index.
package mips_pkg;

  localparam int unsigned MIPS_DATA_W = 32;
  localparam int unsigned MIPS_ADDR_W = 5;

  typedef logic [MIPS_ADDR_W-1:0] reg_addr_t;
  typedef logic [MIPS_DATA_W-1:0] word_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the multi-port register file.
interface reg_file_mp_if import mips_pkg::*; #(
  parameter int unsigned DATA_W = MIPS_DATA_W,
  parameter int unsigned ADDR_W = MIPS_ADDR_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One registered read port: write-first bypass over the stored value plus output registers.
module reg_file_rd_port import mips_pkg::*; #(
  parameter int unsigned DATA_W   = MIPS_DATA_W,
  parameter int unsigned ADDR_W   = MIPS_ADDR_W,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     rd_en_i,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        mem_data_i,
  input  logic                     mem_busy_i,
  // Only priority-winning, zero-masked writes arrive here, so at most one can hit.
  input  logic [NUM_WR-1:0]        wr_win_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_addr_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_busy_o
);

  localparam bit ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_busy_q, rd_busy_d;

  // Next read value: stored state overridden by same-edge write data, then reserve sets busy.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    if (rd_en_i) begin
      rd_data_d = mem_data_i;
      rd_busy_d = mem_busy_i;
      for (int w = 0; w < int'(NUM_WR); w++) begin
        if (wr_win_i[w] && (wr_addr_i[w*ADDR_W +: ADDR_W] == rd_addr_i)) begin
          rd_data_d = wr_data_i[w*DATA_W +: DATA_W];
          rd_busy_d = 1'b0;
        end
      end
      if (rsv_en_i && (rsv_addr_i == rd_addr_i)) begin
        rd_busy_d = 1'b1;
      end
      if (ZeroEn && (rd_addr_i == '0)) begin
        rd_data_d = '0;
        rd_busy_d = 1'b0;
      end
    end
  end

  // Output registers, held between read strobes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file with write-first bypass and per-register pending scoreboard.
module reg_file_mp import mips_pkg::*; #(
  parameter int unsigned DATA_W   = MIPS_DATA_W,
  parameter int unsigned ADDR_W   = MIPS_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam bit          ZeroEn = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;

  logic [NUM_WR-1:0] wr_eff;
  logic [NUM_WR-1:0] wr_win;
  logic              rsv_eff;

  logic [NUM_RD*DATA_W-1:0] rd_data_w;
  logic [NUM_RD-1:0]        rd_busy_w;

  assign rsv_eff = bus.rsv_en && !(ZeroEn && (bus.rsv_addr == '0));

  // Write-priority resolution: a port wins unless a higher-index port writes the same address.
  for (genvar w = 0; w < int'(NUM_WR); w++) begin : g_wr
    logic [ADDR_W-1:0] addr_w;
    logic              beaten;

    assign addr_w    = bus.wr_addr[w*ADDR_W +: ADDR_W];
    assign wr_eff[w] = bus.wr_en[w] && !(ZeroEn && (addr_w == '0));

    // Flag this port as overridden by any higher-priority port to the same address.
    always_comb begin
      beaten = 1'b0;
      for (int h = w + 1; h < int'(NUM_WR); h++) begin
        if (wr_eff[h] && (bus.wr_addr[h*ADDR_W +: ADDR_W] == addr_w)) begin
          beaten = 1'b1;
        end
      end
    end

    assign wr_win[w] = wr_eff[w] && !beaten;
  end

  // Storage and scoreboard next state: winning writes clear pending, a reserve then sets it.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    for (int w = 0; w < int'(NUM_WR); w++) begin
      if (wr_win[w]) begin
        mem_d[bus.wr_addr[w*ADDR_W +: ADDR_W]]     = bus.wr_data[w*DATA_W +: DATA_W];
        pending_d[bus.wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_eff) begin
      pending_d[bus.rsv_addr] = 1'b1;
    end
  end

  // Storage and scoreboard registers; reset drops any in-flight state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] addr_p;
    logic [DATA_W-1:0] mem_data_p;
    logic              mem_busy_p;

    assign addr_p     = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign mem_data_p = mem_q[addr_p];
    assign mem_busy_p = pending_q[addr_p];

    reg_file_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .clk_i      (clk),
      .rst_i      (rst),
      .rd_en_i    (bus.rd_en[p]),
      .rd_addr_i  (addr_p),
      .mem_data_i (mem_data_p),
      .mem_busy_i (mem_busy_p),
      .wr_win_i   (wr_win),
      .wr_addr_i  (bus.wr_addr),
      .wr_data_i  (bus.wr_data),
      .rsv_en_i   (rsv_eff),
      .rsv_addr_i (bus.rsv_addr),
      .rd_data_o  (rd_data_w[p*DATA_W +: DATA_W]),
      .rd_busy_o  (rd_busy_w[p])
    );
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an array-based model of the register file.
module tb_reg_file_mp;
  import mips_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  reg_file_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .NUM_WR   (NW),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model state: architectural registers, pending bits, and what each read port shows.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_pend [DEPTH];
  logic [DW-1:0] m_rd   [NR];
  bit            m_busy [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    for (int p = 0; p < NR; p++) begin
      m_rd[p]   = '0;
      m_busy[p] = 1'b0;
    end
  endtask

  // Apply one clock edge: writes in port order (later port overwrites), reserve last,
  // then reads observe the post-edge state; register 0 is hardwired.
  task automatic model_edge();
    logic [DW-1:0] nm [DEPTH];
    bit            np [DEPTH];
    int            a;
    nm = m_mem;
    np = m_pend;
    for (int w = 0; w < NW; w++) begin
      a = int'(bus.wr_addr[w*AW +: AW]);
      if (bus.wr_en[w] && a != 0) begin
        nm[a] = bus.wr_data[w*DW +: DW];
        np[a] = 1'b0;
      end
    end
    if (bus.rsv_en && bus.rsv_addr != REG_ZERO) np[int'(bus.rsv_addr)] = 1'b1;
    for (int p = 0; p < NR; p++) begin
      if (bus.rd_en[p]) begin
        a         = int'(bus.rd_addr[p*AW +: AW]);
        m_rd[p]   = (a == 0) ? '0 : nm[a];
        m_busy[p] = (a == 0) ? 1'b0 : np[a];
      end
    end
    m_mem  = nm;
    m_pend = np;
  endtask

  task automatic clear_inputs();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
    bus.wr_en[w]            = 1'b1;
    bus.wr_addr[w*AW +: AW] = AW'(a);
    bus.wr_data[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int p, input int a);
    bus.rd_en[p]            = 1'b1;
    bus.rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  // One edge with the current inputs; returns 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_rd(input string name, input int p, input logic [DW-1:0] d, input bit b);
    check({name, "_data"}, 64'(bus.rd_data[p*DW +: DW]), 64'(d));
    check({name, "_busy"}, 64'(bus.rd_busy[p]), 64'(b));
  endtask

  // Every-cycle comparison of all read ports against the model.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      for (int p = 0; p < NR; p++) begin
        check($sformatf("cyc_rd_data%0d", p), 64'(bus.rd_data[p*DW +: DW]), 64'(m_rd[p]));
        check($sformatf("cyc_rd_busy%0d", p), 64'(bus.rd_busy[p]), 64'(m_busy[p]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_data", 64'(bus.rd_data), 64'(0));
    check("reset_rd_busy", 64'(bus.rd_busy), 64'(0));
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Reset discards a written value and clears outputs immediately.
    set_wr(0, 3, 32'hDEAD);
    tick();
    clear_inputs();
    set_rd(0, 3);
    tick();
    clear_inputs();
    chk_rd("t1_pre", 0, 32'hDEAD, 1'b0);
    rst = 1'b1;
    #1;
    check("t1_async_data", 64'(bus.rd_data), 64'(0));
    check("t1_async_busy", 64'(bus.rd_busy), 64'(0));
    model_reset();
    #2;
    rst = 1'b0;
    set_rd(0, 3);
    tick();
    clear_inputs();
    chk_rd("t1_post", 0, 32'h0, 1'b0);

    // Basic write then dual-port read.
    set_wr(0, 5, 32'h12345678);
    tick();
    clear_inputs();
    set_rd(0, 5);
    set_rd(1, 5);
    tick();
    clear_inputs();
    chk_rd("t2_p0", 0, 32'h12345678, 1'b0);
    chk_rd("t2_p1", 1, 32'h12345678, 1'b0);

    // Same-cycle double write: higher port wins, bypassed to the read.
    set_wr(0, 7, 32'h1);
    set_wr(1, 7, 32'h2);
    set_rd(0, 7);
    tick();
    clear_inputs();
    chk_rd("t3_bypass", 0, 32'h2, 1'b0);
    set_rd(1, 7);
    tick();
    clear_inputs();
    chk_rd("t3_later", 1, 32'h2, 1'b0);

    // Scoreboard: reserve, observe busy, then write clears it with bypass.
    set_rsv(9);
    tick();
    clear_inputs();
    set_rd(0, 9);
    tick();
    clear_inputs();
    check("t4_busy", 64'(bus.rd_busy[0]), 64'(1));
    set_wr(0, 9, 32'h55);
    set_rd(0, 9);
    tick();
    clear_inputs();
    chk_rd("t4_clear", 0, 32'h55, 1'b0);

    // Reserve and write in the same cycle: data written, pending remains set.
    set_rsv(4);
    set_wr(1, 4, 32'hAA);
    set_rd(0, 4);
    tick();
    clear_inputs();
    chk_rd("t5_setwins", 0, 32'hAA, 1'b1);

    // Register 0 ignores writes and reserves.
    set_wr(0, 0, 32'hFFFFFFFF);
    set_rsv(0);
    set_rd(0, 0);
    set_rd(1, 0);
    tick();
    clear_inputs();
    chk_rd("t6_same_p0", 0, 32'h0, 1'b0);
    chk_rd("t6_same_p1", 1, 32'h0, 1'b0);
    set_rd(0, 0);
    tick();
    clear_inputs();
    chk_rd("t6_next", 0, 32'h0, 1'b0);

    // Randomized traffic over a narrow address range to force collisions.
    for (int c = 0; c < 3000; c++) begin
      bus.rd_en  = NR'($urandom);
      bus.wr_en  = NW'($urandom);
      bus.rsv_en = 1'($urandom_range(0, 2) == 0);
      bus.rsv_addr = AW'($urandom_range(0, 7));
      for (int p = 0; p < NR; p++) bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) begin
        bus.wr_addr[w*AW +: AW] = AW'($urandom_range(0, 7));
        bus.wr_data[w*DW +: DW] = DW'($urandom);
      end
      tick();
    end
    clear_inputs();
    tick();
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
